// File: rtl/serial_add_sub_if.sv
// ----------------------------------------------------------------------------
// serial_add_sub_if
// Request/result bundle for the bit-serial adder/subtractor.
//   Start, Sub, A, B (Cin) : request side, driven by the master
//   Busy, Done, Sum, Carry, Overflow : result side, driven by the slave
// Optional macro SERIAL_ADD_SUB_CIN_EN adds the Cin request signal.
// ----------------------------------------------------------------------------
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic             Sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SERIAL_ADD_SUB_CIN_EN
    logic             Cin;
`endif
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Carry;
    logic             Overflow;

    modport master (
        output Start, Sub, A, B,
`ifdef SERIAL_ADD_SUB_CIN_EN
        output Cin,
`endif
        input  Busy, Done, Sum, Carry, Overflow
    );

    modport slave (
        input  Start, Sub, A, B,
`ifdef SERIAL_ADD_SUB_CIN_EN
        input  Cin,
`endif
        output Busy, Done, Sum, Carry, Overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// ----------------------------------------------------------------------------
// serial_add_sub
// Bit-serial adder/subtractor: one full-adder cell with a registered carry,
// one bit per clock, LSB first. Subtraction is A + ~B + 1.
//   Clk   : rising-edge clock
//   Rst_n : asynchronous active-low reset
//   bus   : serial_add_sub_if.slave (Start/Sub/A/B in, Busy/Done/Sum/Carry/
//           Overflow out)
// Optional macro SERIAL_ADD_SUB_CIN_EN: adds bus.Cin as carry-in (add) or
// borrow-in (subtract) for multi-word chaining.
// ----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic            Clk,
    input  logic            Rst_n,
    serial_add_sub_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;     // bits already computed, MSB-aligned
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic s_bit, c_next, init_c, accept;

    always_comb begin
        s_bit  = a_q[0] ^ b_q[0] ^ c_q;
        c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
`ifdef SERIAL_ADD_SUB_CIN_EN
        init_c = bus.Sub ? ~bus.Cin : bus.Cin;
`else
        init_c = bus.Sub;
`endif
    end

    // New requests are taken in IDLE and in the DONE cycle (back-to-back).
    assign accept = bus.Start && (state_q != RUN);

    // NOTE: every always_comb target gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = c_next;
            res_d = (WIDTH-1)'({s_bit, res_q} >> 1);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
                sum_d   = {s_bit, res_q};
                carry_d = c_next;
                // c_q is the carry into the MSB on this edge.
                ovf_d   = c_q ^ c_next;
                state_d = DONE;
            end
        end else begin
            if (state_q == DONE) state_d = IDLE;
            if (accept) begin
                a_d     = bus.A;
                b_d     = bus.Sub ? ~bus.B : bus.B;
                c_d     = init_c;
                cnt_d   = '0;
                res_d   = '0;
                state_d = RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Busy     = (state_q == RUN);
    assign bus.Done     = (state_q == DONE);
    assign bus.Sum      = sum_q;
    assign bus.Carry    = carry_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// ----------------------------------------------------------------------------
// tb_serial_add_sub
// Directed, table-driven bench for serial_add_sub (WIDTH=8) with hand-written
// sequences for ignored Start, back-to-back Start, and mid-operation reset.
// ----------------------------------------------------------------------------
module tb_serial_add_sub;
    localparam int WIDTH = 8;

    logic Clk;
    logic Rst_n;

    serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives a one-cycle Start at a falling edge; returns at the next falling
    // edge, i.e. just after the edge that sampled Start.
    task automatic start_op(input logic sub, input logic [7:0] a, input logic [7:0] b,
                            input logic cin);
        bus.Start = 1'b1;
        bus.Sub   = sub;
        bus.A     = a;
        bus.B     = b;
`ifdef SERIAL_ADD_SUB_CIN_EN
        bus.Cin   = cin;
`endif
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.A     = ~a;      // operands may change freely after the Start edge
        bus.B     = ~b;
        bus.Sub   = ~sub;
`ifdef SERIAL_ADD_SUB_CIN_EN
        bus.Cin   = ~cin;
`else
        if (cin) $display("note: cin ignored in this build");
`endif
    endtask

    // Counts falling edges until Done, tallying Busy and watching that the
    // held result does not move before completion.
    task automatic wait_done(input string name, output int n, output int busy_n);
        logic [7:0] held;
        logic       moved;
        held   = bus.Sum;
        moved  = 1'b0;
        n      = 0;
        busy_n = 0;
        while (!bus.Done && n < 50) begin
            if (bus.Busy) busy_n++;
            if (bus.Sum !== held) moved = 1'b1;
            @(negedge Clk);
            n++;
        end
        check({name, "_done_seen"}, bus.Done, 1);
        check({name, "_no_partial"}, moved, 0);
    endtask

    task automatic check_result(input string name, input vec_t v);
        check({name, "_sum"}, bus.Sum, v.sum);
        check({name, "_carry"}, bus.Carry, v.carry);
        check({name, "_ovf"}, bus.Overflow, v.ovf);
        check({name, "_busy_low"}, bus.Busy, 0);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int n, busy_n;
        start_op(v.sub, v.a, v.b, v.cin);
        wait_done(name, n, busy_n);
        check({name, "_latency"}, n, 8);
        check({name, "_busy_cycles"}, busy_n, 8);
        check_result(name, v);
        @(negedge Clk);
        check({name, "_done_pulse"}, bus.Done, 0);
    endtask

    vec_t vecs [11];

    initial begin
        int n, busy_n;

        //          sub   a      b      cin   sum    c     ovf
        vecs[0]  = '{1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h20, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'hC3, 8'h3C, 1'b0, 8'h87, 1'b1, 1'b0};

        Rst_n     = 1'b0;
        bus.Start = 1'b0;
        bus.Sub   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
`ifdef SERIAL_ADD_SUB_CIN_EN
        bus.Cin   = 1'b0;
`endif
        repeat (2) @(negedge Clk);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_sum", bus.Sum, 0);
        check("rst_carry", bus.Carry, 0);
        check("rst_ovf", bus.Overflow, 0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        check("idle_busy", bus.Busy, 0);

        for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Start during RUN is ignored; Start held in the DONE cycle is taken.
        start_op(1'b0, 8'h0F, 8'h01, 1'b0);
        repeat (2) @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = 8'h01;
        bus.B     = 8'h01;
        bus.Sub   = 1'b0;
        @(negedge Clk);
        bus.Start = 1'b0;
        wait_done("ign", n, busy_n);
        check("ign_latency", n, 5);
        check("ign_sum", bus.Sum, 8'h10);
        bus.Start = 1'b1;
        bus.A     = 8'h03;
        bus.B     = 8'h04;
        bus.Sub   = 1'b0;
        @(negedge Clk);
        bus.Start = 1'b0;
        check("b2b_busy_now", bus.Busy, 1);
        check("b2b_done_dropped", bus.Done, 0);
        check("b2b_held_sum", bus.Sum, 8'h10);
        wait_done("b2b", n, busy_n);
        check("b2b_gap", n + 1, 9);
        check("b2b_sum", bus.Sum, 8'h07);
        @(negedge Clk);

        // Reset during bit 4, released together with a fresh Start.
        start_op(1'b0, 8'hAA, 8'h55, 1'b0);
        repeat (4) @(negedge Clk);
        check("mid_busy", bus.Busy, 1);
        Rst_n = 1'b0;
        #1;
        check("arst_busy", bus.Busy, 0);
        check("arst_done", bus.Done, 0);
        check("arst_sum", bus.Sum, 0);
        check("arst_carry", bus.Carry, 0);
        check("arst_ovf", bus.Overflow, 0);
        @(negedge Clk);
        check("arst_held_sum", bus.Sum, 0);
        Rst_n = 1'b1;
        start_op(1'b0, 8'h01, 8'h02, 1'b0);
        wait_done("post_rst", n, busy_n);
        check("post_rst_latency", n, 8);
        check("post_rst_sum", bus.Sum, 8'h03);
        check("post_rst_carry", bus.Carry, 0);
        @(negedge Clk);

`ifdef SERIAL_ADD_SUB_CIN_EN
        run_vec("cin_add", '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
        run_vec("cin_sub", '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0});
        run_vec("cin_add0", '{1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor: latches two WIDTH-bit operands on Start and processes one bit per clock, LSB first, through a single full-adder cell with a registered carry.
- It is the sequential, bidirectional counterpart of the combinational full adder: same Sum/Carry semantics, plus subtraction as the inverse operation.
- Used where area matters more than latency; results are presented with a one-cycle Done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- Clk  input  1  system clock, rising-edge active.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only when not Busy.
- Sub  input  1  operation select, sampled with Start: 0 = A+B, 1 = A-B.
- A  input  WIDTH  operand A, sampled with Start.
- B  input  WIDTH  operand B, sampled with Start.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse when Sum/Carry/Overflow are updated.
- Sum  output  WIDTH  result, held until the next completion.
- Carry  output  1  carry out of the MSB; for Sub it is the not-borrow flag (1 when A >= B unsigned).
- Overflow  output  1  signed two's-complement overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- Clocking and reset: one clock (Clk). Rst_n is asynchronous and active-low.
- Reset values: Busy=0, Done=0, Sum=0, Carry=0, Overflow=0. The FSM goes to IDLE; the bit counter, carry register and shift registers clear.
- FSM states: IDLE, RUN, DONE.
- IDLE: if Start=1 at a clock edge:
  - latch A, and B (or ~B when Sub=1) into shift registers;
  - carry register <= Sub;
  - counter <= 0;
  - go to RUN, Busy=1.
  - If Start=0, stay in IDLE.
- RUN: each edge computes one full-adder bit.
  - s = a0 ^ b0 ^ c; c' = a0&b0 | a0&c | b0&c.
  - s shifts into the result register from the MSB side; operands shift right; counter increments.
  - Start is ignored in RUN.
  - On the edge that processes bit WIDTH-1: Sum <= complete result, Carry <= c', Overflow <= carry-in of bit WIDTH-1 XOR c'. Go to DONE with Busy=0 and Done=1.
- DONE: lasts exactly one cycle, then goes to IDLE and Done returns to 0.
  - Start=1 in DONE is accepted exactly as in IDLE, going straight to RUN. This gives back-to-back operation with no idle gap.
- Latency: with Start sampled at edge 0, bits are processed at edges 1..WIDTH. Done is high between edge WIDTH and edge WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- Sum, Carry and Overflow change only on the completion edge. Partial results are never visible.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- A, B and Sub may change freely after the Start edge.
- Reset mid-operation: the operation is aborted with no Done pulse and outputs return to their reset values. The next Start after reset deasserts operates normally.
- Start and reset deasserting in the same cycle: Start is sampled on the first edge after reset release.

Optional Feature:
- Macro: SERIAL_ADD_SUB_CIN_EN.
- With the macro defined:
  - an extra input port Cin (1 bit) is sampled with Start;
  - Add: initial carry = Cin, giving A+B+Cin.
  - Sub: initial carry = ~Cin, with Cin acting as borrow-in, giving A-B-Cin.
  - This allows multi-word chaining from the previous Carry.
- Without the macro: no Cin port; the initial carry is 0 for add and 1 for subtract.

Test Plan:
- Add, WIDTH=8, A=0x5A, B=0x33, Sub=0 -> after 8 RUN cycles, Done pulses once; Sum=0x8D, Carry=0, Overflow=1. Busy was high for exactly 8 cycles.
- Add wrap: A=0xFF, B=0x01 -> Sum=0x00, Carry=1, Overflow=0. Then subtract A=0x80, B=0x01 -> Sum=0x7F, Carry=1, Overflow=1.
- Subtract with borrow: A=0x10, B=0x20, Sub=1 -> Sum=0xF0, Carry=0, Overflow=0. Then A=0x20, B=0x20 -> Sum=0x00, Carry=1.
- Start pulsed with A=0x01, B=0x01 during RUN of an active A=0x0F, B=0x01 add -> request ignored; single Done with Sum=0x10. Start held high in the DONE cycle with A=0x03, B=0x04 -> next result Sum=0x07 with Done exactly 9 cycles later.
- Rst_n low for 1 cycle during bit 4 of A=0xAA, B=0x55 -> all outputs 0 immediately, no Done. Fresh add A=0x01, B=0x02 -> Sum=0x03.
- With SERIAL_ADD_SUB_CIN_EN: A=0xFF, B=0x00, Cin=1 add -> Sum=0x00, Carry=1. A=0x00, B=0x00, Cin=1 sub -> Sum=0xFF, Carry=0.
